// File: rtl/record_banner_overlay.sv
`default_nettype none
// ============================================================================
// Module   : record_banner_overlay
// Purpose  : Overlays the "break record time" bitmap onto the VGA colour
//            stream after a new-record event. The text blinks on a frame
//            period for a fixed number of frames, then the block returns to
//            pass-through. Fixed 2-cycle latency from scan inputs to rgb_out.
// Revision : 1.0 - initial release
// ============================================================================
module record_banner_overlay #(
  parameter int          X0           = 188,
  parameter int          Y0           = 228,
  parameter int          W            = 264,
  parameter int          H            = 24,
  parameter int          SHOW_FRAMES  = 180,
  parameter int          BLINK_FRAMES = 15,
  parameter logic [11:0] FG_RGB       = 12'hFF0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [9:0]     h_cnt,
  input  logic [9:0]     v_cnt,
  input  logic           video_on,
  input  logic           frame_start,
  input  logic           record_pulse,
  input  logic [W*H-1:0] bitmap,
  input  logic [11:0]    bg_rgb,
  output logic [11:0]    rgb_out,
  output logic           pixel_on,
  output logic           banner_active
);

  localparam int FC_W  = (SHOW_FRAMES  > 1) ? $clog2(SHOW_FRAMES)  : 1;
  localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int IDX_W = $clog2(W*H);

  // Box bounds widened to 11 bits so the upper limits never wrap.
  localparam logic [10:0]     C_X_LO       = 11'(X0);
  localparam logic [10:0]     C_X_HI       = 11'(X0 + W);
  localparam logic [10:0]     C_Y_LO       = 11'(Y0);
  localparam logic [10:0]     C_Y_HI       = 11'(Y0 + H);
  localparam logic [FC_W-1:0] C_FRAME_LAST = FC_W'(SHOW_FRAMES - 1);
  localparam logic [BC_W-1:0] C_BLINK_LAST = BC_W'(BLINK_FRAMES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  state_t          state_q;
  logic            visible_q;
  logic [FC_W-1:0] frame_cnt_q;
  logic [BC_W-1:0] blink_cnt_q;
  logic            banner_active_q;

  logic            s1_in_box_q;
  logic [4:0]      s1_row_q;
  logic [8:0]      s1_col_q;
  logic            s1_vid_q;
  logic [11:0]     s1_bg_q;

  logic [11:0]     rgb_q;
  logic            pixel_on_q;

  // ---------------------------------------------------------------------------
  // Stage-1 next-state: box test and in-banner coordinates
  // ---------------------------------------------------------------------------
  logic [10:0] w_h_ext;
  logic [10:0] w_v_ext;
  logic        in_box_d;
  logic [4:0]  row_d;
  logic [8:0]  col_d;

  assign w_h_ext  = {1'b0, h_cnt};
  assign w_v_ext  = {1'b0, v_cnt};
  assign in_box_d = video_on &&
                    (w_h_ext >= C_X_LO) && (w_h_ext < C_X_HI) &&
                    (w_v_ext >= C_Y_LO) && (w_v_ext < C_Y_HI);
  // Outside the box the coordinates are forced to 0 so the bitmap index
  // computed in stage 2 always stays inside the ROM vector.
  assign row_d    = in_box_d ? 5'(w_v_ext - C_Y_LO) : 5'd0;
  assign col_d    = in_box_d ? 9'(w_h_ext - C_X_LO) : 9'd0;

  // ---------------------------------------------------------------------------
  // Stage-2 next-state: bitmap lookup and colour select
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] w_bit_idx;
  logic             w_bit;
  logic             draw_d;
  logic [11:0]      rgb_d;

  // Row r starts at bit r*W; column 0 is the MSB of that row.
  assign w_bit_idx = (IDX_W'(s1_row_q) * IDX_W'(W)) + IDX_W'(W - 1) - IDX_W'(s1_col_q);
  assign w_bit     = bitmap[w_bit_idx];
  assign draw_d    = s1_in_box_q && visible_q && (state_q == ST_SHOW) && w_bit;
  assign rgb_d     = !s1_vid_q ? 12'h000 : (draw_d ? FG_RGB : s1_bg_q);

  // Banner sequencer: start/restart on record_pulse, count frames, blink, time out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      visible_q   <= 1'b0;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (record_pulse) begin
            state_q     <= ST_SHOW;
            visible_q   <= 1'b1;
            frame_cnt_q <= '0;
            blink_cnt_q <= '0;
          end
        end
        ST_SHOW: begin
          if (record_pulse) begin
            // A new record restarts the sequence and swallows a coincident
            // frame_start, including the final one.
            visible_q   <= 1'b1;
            frame_cnt_q <= '0;
            blink_cnt_q <= '0;
          end else if (frame_start) begin
            if (frame_cnt_q == C_FRAME_LAST) begin
              state_q     <= ST_IDLE;
              visible_q   <= 1'b0;
              frame_cnt_q <= '0;
              blink_cnt_q <= '0;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
              if (blink_cnt_q == C_BLINK_LAST) begin
                visible_q   <= ~visible_q;
                blink_cnt_q <= '0;
              end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
              end
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          visible_q   <= 1'b0;
          frame_cnt_q <= '0;
          blink_cnt_q <= '0;
        end
      endcase
    end
  end

  // Registered status flag: follows the sequencer state one cycle later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      banner_active_q <= 1'b0;
    end else begin
      banner_active_q <= (state_q == ST_SHOW);
    end
  end

  // Stage 1: capture box test, coordinates, blanking qualifier and scene colour
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_in_box_q <= 1'b0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      s1_vid_q    <= 1'b0;
      s1_bg_q     <= '0;
    end else begin
      s1_in_box_q <= in_box_d;
      s1_row_q    <= row_d;
      s1_col_q    <= col_d;
      s1_vid_q    <= video_on;
      s1_bg_q     <= bg_rgb;
    end
  end

  // Stage 2: register the final pixel colour and draw flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_q      <= '0;
      pixel_on_q <= 1'b0;
    end else begin
      rgb_q      <= rgb_d;
      pixel_on_q <= draw_d;
    end
  end

  assign rgb_out       = rgb_q;
  assign pixel_on      = pixel_on_q;
  assign banner_active = banner_active_q;

endmodule
`default_nettype wire

// File: tb/tb_record_banner_overlay.sv
`default_nettype none
// ============================================================================
// Module   : tb_record_banner_overlay
// Purpose  : Self-checking bench for record_banner_overlay. Directed table
//            vectors, hand-written blink/restart/reset sequences and a
//            randomized run compared every cycle against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_record_banner_overlay;

  localparam int          X0    = 188;
  localparam int          Y0    = 228;
  localparam int          W     = 264;
  localparam int          H     = 24;
  localparam int          SHOW  = 7;
  localparam int          BLINK = 2;
  localparam logic [11:0] FG    = 12'hFF0;

  logic           clk          = 1'b0;
  logic           rst_n        = 1'b0;
  logic [9:0]     h_cnt        = '0;
  logic [9:0]     v_cnt        = '0;
  logic           video_on     = 1'b0;
  logic           frame_start  = 1'b0;
  logic           record_pulse = 1'b0;
  logic [W*H-1:0] bitmap       = '0;
  logic [11:0]    bg_rgb       = '0;
  logic [11:0]    rgb_out;
  logic           pixel_on;
  logic           banner_active;

  record_banner_overlay #(
    .X0(X0), .Y0(Y0), .W(W), .H(H),
    .SHOW_FRAMES(SHOW), .BLINK_FRAMES(BLINK), .FG_RGB(FG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .video_on(video_on), .frame_start(frame_start), .record_pulse(record_pulse),
    .bitmap(bitmap), .bg_rgb(bg_rgb), .rgb_out(rgb_out),
    .pixel_on(pixel_on), .banner_active(banner_active)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b1;

  // Reference model: banner described by "frames counted since last record"
  bit          m_active = 1'b0;
  int          m_n      = 0;
  int          p_h      = 0;
  int          p_v      = 0;
  bit          p_vid    = 1'b0;
  logic [11:0] p_bg     = '0;
  logic [11:0] e_rgb    = '0;
  bit          e_pix    = 1'b0;
  bit          e_act    = 1'b0;

  function automatic bit model_bit(int r, int c);
    return bitmap[r*W + (W-1-c)];
  endfunction

  task automatic chk(string nm, logic [11:0] x_rgb, bit x_pix, bit x_act, bit use_act);
    n_vec++;
    if (rgb_out !== x_rgb || pixel_on !== x_pix || (use_act && banner_active !== x_act)) begin
      n_err++;
      $display("FAIL %s @%0t: got rgb=%h pix=%b act=%b, want rgb=%h pix=%b act=%b",
               nm, $time, rgb_out, pixel_on, banner_active, x_rgb, x_pix, x_act);
    end
  endtask

  task automatic chk_act(string nm, bit x_act);
    n_vec++;
    if (banner_active !== x_act) begin
      n_err++;
      $display("FAIL %s @%0t: got banner_active=%b, want %b", nm, $time, banner_active, x_act);
    end
  endtask

  // Per-edge model step and comparison against the DUT
  always @(posedge clk) begin
    if (!rst_n) begin
      e_rgb = '0; e_pix = 1'b0; e_act = 1'b0;
      m_active = 1'b0; m_n = 0; p_vid = 1'b0;
    end else begin
      e_act = m_active;
      e_pix = p_vid && p_h >= X0 && p_h < X0 + W && p_v >= Y0 && p_v < Y0 + H &&
              m_active && ((m_n / BLINK) % 2 == 0) && model_bit(p_v - Y0, p_h - X0);
      e_rgb = !p_vid ? 12'h000 : (e_pix ? FG : p_bg);
      if (record_pulse) begin
        m_active = 1'b1; m_n = 0;
      end else if (frame_start && m_active) begin
        m_n++;
        if (m_n == SHOW) begin m_active = 1'b0; m_n = 0; end
      end
      p_h = int'(h_cnt); p_v = int'(v_cnt); p_vid = video_on; p_bg = bg_rgb;
    end
    if (chk_en) begin
      #1;
      chk("model", e_rgb, e_pix, e_act, 1'b1);
    end
  end

  task automatic edge_chk();
    @(posedge clk); #1;
  endtask

  task automatic pulse_rec();
    @(negedge clk); record_pulse = 1'b1;
    @(negedge clk); record_pulse = 1'b0;
  endtask

  task automatic pulse_fs();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic drive(int h, int v, bit vid, logic [11:0] bg);
    @(negedge clk);
    h_cnt = 10'(h); v_cnt = 10'(v); video_on = vid; bg_rgb = bg;
  endtask

  typedef struct {
    int          h;
    int          v;
    bit          vid;
    logic [11:0] bg;
    bit          ones;
    logic [11:0] x_rgb;
    bit          x_pix;
  } vec_t;

  vec_t tbl[13];
  bit   pat[7];

  initial begin
    tbl[0]  = '{188, 228, 1'b1, 12'h123, 1'b0, 12'hFF0, 1'b1};
    tbl[1]  = '{189, 228, 1'b1, 12'h456, 1'b0, 12'h456, 1'b0};
    tbl[2]  = '{187, 228, 1'b1, 12'h789, 1'b0, 12'h789, 1'b0};
    tbl[3]  = '{188, 227, 1'b1, 12'h0AA, 1'b0, 12'h0AA, 1'b0};
    tbl[4]  = '{188, 229, 1'b1, 12'h0BB, 1'b0, 12'h0BB, 1'b0};
    tbl[5]  = '{188, 228, 1'b0, 12'h555, 1'b0, 12'h000, 1'b0};
    tbl[6]  = '{451, 251, 1'b1, 12'h111, 1'b1, 12'hFF0, 1'b1};
    tbl[7]  = '{452, 251, 1'b1, 12'h222, 1'b1, 12'h222, 1'b0};
    tbl[8]  = '{451, 252, 1'b1, 12'h333, 1'b1, 12'h333, 1'b0};
    tbl[9]  = '{188, 228, 1'b1, 12'h444, 1'b1, 12'hFF0, 1'b1};
    tbl[10] = '{300, 240, 1'b0, 12'h666, 1'b1, 12'h000, 1'b0};
    tbl[11] = '{1023, 1023, 1'b1, 12'h777, 1'b1, 12'h777, 1'b0};
    tbl[12] = '{0, 0, 1'b1, 12'h888, 1'b1, 12'h888, 1'b0};
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held for 3 clocks with live scene colour
    rst_n = 1'b0; video_on = 1'b1; bg_rgb = 12'hABC;
    repeat (2) @(posedge clk);
    edge_chk(); chk("reset", 12'h000, 1'b0, 1'b0, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    edge_chk(); chk("post_rst_1", 12'h000, 1'b0, 1'b0, 1'b1);
    edge_chk(); chk("post_rst_2", 12'hABC, 1'b0, 1'b0, 1'b1);

    // Directed table in SHOW with visible=1
    pulse_rec();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (tbl[i].ones) bitmap = '1;
      else begin bitmap = '0; bitmap[W-1] = 1'b1; end
      drive(tbl[i].h, tbl[i].v, tbl[i].vid, tbl[i].bg);
      repeat (2) @(posedge clk); #1;
      chk($sformatf("tbl%0d", i), tbl[i].x_rgb, tbl[i].x_pix, 1'b1, 1'b1);
    end

    // Let the current banner expire before the blink sequence
    repeat (SHOW) pulse_fs();
    repeat (3) @(posedge clk);

    // Blink pattern and timeout
    @(negedge clk); bitmap = '1;
    drive(188, 228, 1'b1, 12'h123);
    pulse_rec();
    repeat (2) @(posedge clk); #1;
    chk("blink_f0", pat[0] ? FG : 12'h123, pat[0], 1'b1, 1'b1);
    for (int f = 1; f < SHOW; f++) begin
      pulse_fs();
      repeat (2) @(posedge clk); #1;
      chk($sformatf("blink_f%0d", f), pat[f] ? FG : 12'h123, pat[f], 1'b1, 1'b1);
    end
    pulse_fs();
    edge_chk(); chk_act("timeout_act", 1'b0);
    edge_chk(); chk("timeout_pass", 12'h123, 1'b0, 1'b0, 1'b1);

    // Restart coincident with the final frame_start
    pulse_rec();
    repeat (SHOW - 1) pulse_fs();
    @(negedge clk); frame_start = 1'b1; record_pulse = 1'b1;
    @(negedge clk); frame_start = 1'b0; record_pulse = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("restart", FG, 1'b1, 1'b1, 1'b1);
    repeat (SHOW - 1) pulse_fs();
    repeat (2) @(posedge clk); #1;
    chk_act("restart_still", 1'b1);
    pulse_fs();
    repeat (2) @(posedge clk); #1;
    chk("restart_exit", 12'h123, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of SHOW
    pulse_rec();
    repeat (3) pulse_fs();
    @(negedge clk); rst_n = 1'b0;
    edge_chk(); chk("mid_rst", 12'h000, 1'b0, 1'b0, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("mid_rst_idle", 12'h123, 1'b0, 1'b0, 1'b1);
    pulse_rec();
    repeat (2) @(posedge clk); #1;
    chk("mid_rst_rearm", FG, 1'b1, 1'b1, 1'b1);

    // Randomized run against the model
    for (int i = 0; i < W*H; i++) bitmap[i] = 1'($urandom_range(0, 1));
    pulse_rec();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      h_cnt        = 10'($urandom_range(170, 470));
      v_cnt        = 10'($urandom_range(220, 260));
      video_on     = ($urandom_range(0, 7) != 0);
      bg_rgb       = 12'($urandom);
      frame_start  = ($urandom_range(0, 24) == 0);
      record_pulse = ($urandom_range(0, 299) == 0);
      rst_n        = ($urandom_range(0, 999) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; frame_start = 1'b0; record_pulse = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); chk_en = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
